// File: rtl/ats_flow_input_arbiter.sv
// Frame-granular round-robin arbiter sharing one detect_flow_core between PORT_NUM
// ingress streams; a tag FIFO pairs each returned flow ID with its frame's source port.
module ats_flow_input_arbiter #(
   parameter int DATA_WIDTH     = 8,
   parameter int PORT_NUM       = 4,
   parameter int PORT_WIDTH     = 2,
   parameter int FLOW_WIDTH     = 8,
   parameter int TAG_FIFO_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic [PORT_NUM*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [PORT_NUM-1:0]            s_axis_tvalid,
   output logic [PORT_NUM-1:0]            s_axis_tready,
   input  logic [PORT_NUM-1:0]            s_axis_tlast,
   output logic [DATA_WIDTH-1:0]          m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast,
   input  logic [FLOW_WIDTH-1:0]          s_axis_flow_tdata,
   input  logic                           s_axis_flow_tvalid,
   output logic                           s_axis_flow_tready,
   output logic [FLOW_WIDTH-1:0]          m_axis_flow_tdata,
   output logic [PORT_WIDTH-1:0]          m_axis_flow_tport,
   output logic                           m_axis_flow_tvalid,
   input  logic                           m_axis_flow_tready,
   output logic                           err_orphan_flow
);
   localparam int AW = $clog2(TAG_FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;

   state_t                state_r;
   logic [PORT_WIDTH-1:0] grant_r;
   logic [PORT_WIDTH-1:0] last_grant_r;
   logic [PORT_WIDTH-1:0] tag_mem_r [TAG_FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_r;
   logic [AW-1:0]         rd_ptr_r;
   logic [CW-1:0]         count_r;
   logic                  err_r;

   logic [DATA_WIDTH-1:0] port_data_s [PORT_NUM];
   logic [PORT_WIDTH-1:0] sel_port_s;
   logic [PORT_WIDTH-1:0] idx_s;
   logic                  sel_found_s;
   logic                  fifo_full_s;
   logic                  fifo_empty_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  beat_last_s;

   // Descending scan so the port closest after last_grant overrides the others.
   always_comb begin
      sel_port_s = {PORT_WIDTH{1'b0}};
      idx_s      = {PORT_WIDTH{1'b0}};
      for (int i = PORT_NUM; i >= 1; i--) begin
         idx_s      = PORT_WIDTH'((int'(last_grant_r) + i) % PORT_NUM);
         sel_port_s = s_axis_tvalid[idx_s] ? idx_s : sel_port_s;
      end
      sel_found_s = |s_axis_tvalid;
   end

   always_comb begin
      for (int p = 0; p < PORT_NUM; p++) begin
         port_data_s[p] = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      s_axis_tready = {PORT_NUM{1'b0}};
      if (state_r == ST_STREAM) begin
         m_axis_tdata           = port_data_s[grant_r];
         m_axis_tvalid          = s_axis_tvalid[grant_r];
         m_axis_tlast           = s_axis_tlast[grant_r];
         s_axis_tready[grant_r] = m_axis_tready;
      end else begin
         m_axis_tdata  = {DATA_WIDTH{1'b0}};
         m_axis_tvalid = 1'b0;
         m_axis_tlast  = 1'b0;
      end
   end

   // Full is judged on the registered count, so a same-cycle pop cannot unblock a grant.
   assign fifo_full_s        = (count_r == CW'(TAG_FIFO_DEPTH));
   assign fifo_empty_s       = (count_r == {CW{1'b0}});
   assign push_s             = (state_r == ST_IDLE) && sel_found_s && !fifo_full_s;
   assign pop_s              = s_axis_flow_tvalid && s_axis_flow_tready;
   assign beat_last_s        = m_axis_tvalid && m_axis_tready && m_axis_tlast;

   assign m_axis_flow_tvalid = s_axis_flow_tvalid && !fifo_empty_s;
   assign s_axis_flow_tready = m_axis_flow_tready && !fifo_empty_s;
   assign m_axis_flow_tdata  = s_axis_flow_tdata;
   assign m_axis_flow_tport  = tag_mem_r[rd_ptr_r];
   assign err_orphan_flow    = err_r;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r      <= ST_IDLE;
         grant_r      <= {PORT_WIDTH{1'b0}};
         last_grant_r <= PORT_WIDTH'(PORT_NUM - 1);
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (push_s) begin
                  grant_r      <= sel_port_s;
                  last_grant_r <= sel_port_s;
                  state_r      <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (beat_last_s) begin
                  state_r <= ST_IDLE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < TAG_FIFO_DEPTH; i++) begin
            tag_mem_r[i] <= {PORT_WIDTH{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         err_r    <= 1'b0;
      end else begin
         if (push_s) begin
            tag_mem_r[wr_ptr_r] <= sel_port_s;
            wr_ptr_r            <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
         // A flow ID with no outstanding frame is left unaccepted and flagged.
         if (s_axis_flow_tvalid && fifo_empty_s) begin
            err_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ats_flow_input_arbiter.sv
// Scoreboard bench for ats_flow_input_arbiter: per-port source queues, a small
// flow-core model, and expected beat/tag queues checked as the DUT emits output.
module tb_ats_flow_input_arbiter;
   localparam int DW = 8;
   localparam int PN = 4;
   localparam int PW = 2;
   localparam int FW = 8;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rstn;
   logic [PN*DW-1:0] s_axis_tdata;
   logic [PN-1:0]   s_axis_tvalid;
   logic [PN-1:0]   s_axis_tready;
   logic [PN-1:0]   s_axis_tlast;
   logic [DW-1:0]   m_axis_tdata;
   logic            m_axis_tvalid;
   logic            m_axis_tready;
   logic            m_axis_tlast;
   logic [FW-1:0]   s_axis_flow_tdata;
   logic            s_axis_flow_tvalid;
   logic            s_axis_flow_tready;
   logic [FW-1:0]   m_axis_flow_tdata;
   logic [PW-1:0]   m_axis_flow_tport;
   logic            m_axis_flow_tvalid;
   logic            m_axis_flow_tready;
   logic            err_orphan_flow;

   always #5 clk = ~clk;

   ats_flow_input_arbiter #(
      .DATA_WIDTH(DW), .PORT_NUM(PN), .PORT_WIDTH(PW),
      .FLOW_WIDTH(FW), .TAG_FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rstn(rstn),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .s_axis_flow_tdata(s_axis_flow_tdata), .s_axis_flow_tvalid(s_axis_flow_tvalid),
      .s_axis_flow_tready(s_axis_flow_tready), .m_axis_flow_tdata(m_axis_flow_tdata),
      .m_axis_flow_tport(m_axis_flow_tport), .m_axis_flow_tvalid(m_axis_flow_tvalid),
      .m_axis_flow_tready(m_axis_flow_tready), .err_orphan_flow(err_orphan_flow)
   );

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [8:0]    src_q [PN][$];
   logic [8:0]    exp_q [PN][$];
   logic [PW-1:0] tag_q [$];
   logic [FW-1:0] core_q [$];
   int            grant_log [$];
   int            gap_log [$];
   int            beat_cyc_log [$];
   int            flow_port_log [$];
   int            flow_id_log [$];
   bit            in_frame [PN];
   int            last_tlast_cyc;
   int            vpct;
   int            mpct;
   logic          orphan_force;
   logic [FW-1:0] next_id;
   int            viol;
   int            hs_port;
   bit            flow_hs;
   int            pop_cyc;
   bit            pop_seen;
   int            p1_beats;
   bit            rdy_seen;
   logic          snap_err;
   logic          snap_sfr;
   logic          snap_mfv;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_frame(input int p, input int len);
      logic [8:0] w;
      for (int b = 0; b < len; b++) begin
         w = {(b == len - 1), 8'($urandom)};
         src_q[p].push_back(w);
         exp_q[p].push_back(w);
      end
   endtask

   task automatic drive();
      logic [8:0] w;
      for (int p = 0; p < PN; p++) begin
         if (src_q[p].size() > 0 && int'($urandom_range(99)) < vpct) begin
            w = src_q[p][0];
            s_axis_tvalid[p]          = 1'b1;
            s_axis_tdata[p*DW +: DW]  = w[7:0];
            s_axis_tlast[p]           = w[8];
         end else begin
            s_axis_tvalid[p]          = 1'b0;
            s_axis_tdata[p*DW +: DW]  = 8'h00;
            s_axis_tlast[p]           = 1'b0;
         end
      end
      m_axis_tready      = (int'($urandom_range(99)) < mpct);
      s_axis_flow_tvalid = orphan_force || (core_q.size() > 0);
      s_axis_flow_tdata  = orphan_force ? 8'hEE : ((core_q.size() > 0) ? core_q[0] : 8'h00);
   endtask

   task automatic observe();
      int nrdy;
      logic [8:0] e;
      logic [PW-1:0] t;
      nrdy = 0;
      hs_port = -1;
      for (int p = 0; p < PN; p++) begin
         if (s_axis_tready[p]) nrdy++;
         if (s_axis_tready[p] && s_axis_tvalid[p]) hs_port = p;
      end
      if (nrdy > 1) viol++;
      if (nrdy == 1 && !m_axis_tready) viol++;
      if ((m_axis_tvalid && m_axis_tready) != (hs_port >= 0)) viol++;
      if (|s_axis_tready) rdy_seen = 1'b1;
      if (hs_port >= 0) begin
         if (exp_q[hs_port].size() == 0) begin
            viol++;
         end else begin
            e = exp_q[hs_port].pop_front();
            check_eq("beat", {23'd0, m_axis_tlast, m_axis_tdata}, {23'd0, e});
            if (!in_frame[hs_port]) begin
               grant_log.push_back(hs_port);
               gap_log.push_back(cyc - last_tlast_cyc);
               beat_cyc_log.push_back(cyc);
               tag_q.push_back(PW'(hs_port));
            end
            if (hs_port == 1) p1_beats++;
            if (e[8]) begin
               in_frame[hs_port] = 1'b0;
               last_tlast_cyc = cyc;
               core_q.push_back(next_id);
               next_id = next_id + 8'h01;
            end else begin
               in_frame[hs_port] = 1'b1;
            end
         end
      end
      flow_hs = s_axis_flow_tvalid && s_axis_flow_tready;
      if (flow_hs) begin
         if (tag_q.size() == 0 || orphan_force) begin
            viol++;
         end else begin
            t = tag_q.pop_front();
            check_eq("flow_tvalid", {31'd0, m_axis_flow_tvalid}, 32'd1);
            check_eq("flow_tport", {30'd0, m_axis_flow_tport}, {30'd0, t});
            check_eq("flow_tdata", {24'd0, m_axis_flow_tdata}, {24'd0, core_q[0]});
            flow_port_log.push_back(int'(m_axis_flow_tport));
            flow_id_log.push_back(int'(m_axis_flow_tdata));
            if (!pop_seen) begin
               pop_seen = 1'b1;
               pop_cyc = cyc;
            end
         end
      end
      snap_err = err_orphan_flow;
      snap_sfr = s_axis_flow_tready;
      snap_mfv = m_axis_flow_tvalid;
   endtask

   task automatic commit();
      logic [8:0] w;
      logic [FW-1:0] f;
      if (hs_port >= 0 && src_q[hs_port].size() > 0) w = src_q[hs_port].pop_front();
      if (flow_hs && !orphan_force && core_q.size() > 0) f = core_q.pop_front();
   endtask

   task automatic tick();
      drive();
      @(negedge clk);
      cyc++;
      observe();
      @(posedge clk);
      #1;
      commit();
   endtask

   function automatic bit drained();
      bit d;
      d = (core_q.size() == 0) && (tag_q.size() == 0);
      for (int p = 0; p < PN; p++) begin
         if (src_q[p].size() != 0 || exp_q[p].size() != 0) d = 1'b0;
      end
      return d;
   endfunction

   task automatic run_drain(input string tag, input int max);
      int n;
      n = 0;
      while (!drained() && n < max) begin
         tick();
         n++;
      end
      check_eq(tag, {31'd0, drained()}, 32'd1);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      for (int p = 0; p < PN; p++) begin
         src_q[p].delete();
         exp_q[p].delete();
         in_frame[p] = 1'b0;
      end
      tag_q.delete(); core_q.delete();
      grant_log.delete(); gap_log.delete(); beat_cyc_log.delete();
      flow_port_log.delete(); flow_id_log.delete();
      s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tlast = '0;
      s_axis_flow_tvalid = 1'b0; s_axis_flow_tdata = 8'h00;
      orphan_force = 1'b0; viol = 0; pop_seen = 1'b0; p1_beats = 0;
      next_id = 8'h01; rdy_seen = 1'b0; hs_port = -1; flow_hs = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      last_tlast_cyc = cyc - 100;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int valid_cyc;
      vpct = 100; mpct = 100; m_axis_tready = 1'b1; m_axis_flow_tready = 1'b1;
      do_reset();

      // Reset values
      @(negedge clk);
      check_eq("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      check_eq("rst_s_tready", {28'd0, s_axis_tready}, 32'd0);
      check_eq("rst_m_tdata", {24'd0, m_axis_tdata}, 32'd0);
      check_eq("rst_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
      check_eq("rst_flow_tvalid", {31'd0, m_axis_flow_tvalid}, 32'd0);
      check_eq("rst_flow_tready", {31'd0, s_axis_flow_tready}, 32'd0);
      check_eq("rst_err", {31'd0, err_orphan_flow}, 32'd0);
      @(posedge clk);
      #1;

      // Test 1: single 64-byte frame on port 2
      do_reset();
      load_frame(2, 64);
      valid_cyc = cyc + 1;
      run_drain("t1_drain", 400);
      check_eq("t1_nframes", grant_log.size(), 32'd1);
      if (grant_log.size() >= 1 && flow_port_log.size() >= 1) begin
         check_eq("t1_grant", grant_log[0], 32'd2);
         check_eq("t1_latency", beat_cyc_log[0] - valid_cyc, 32'd1);
         check_eq("t1_flow_port", flow_port_log[0], 32'd2);
         check_eq("t1_flow_id", flow_id_log[0], 32'h01);
      end

      // Test 2: fairness, 3 frames on every port
      do_reset();
      for (int f = 0; f < 3; f++) begin
         for (int p = 0; p < PN; p++) load_frame(p, 4);
      end
      run_drain("t2_drain", 500);
      check_eq("t2_nframes", grant_log.size(), 32'd12);
      if (grant_log.size() == 12 && flow_port_log.size() == 12) begin
         for (int i = 0; i < 12; i++) begin
            check_eq("t2_grant_order", grant_log[i], i % PN);
            check_eq("t2_tag_order", flow_port_log[i], i % PN);
            if (i > 0) check_eq("t2_gap", gap_log[i], 32'd2);
         end
      end

      // Test 3: random backpressure and mid-frame valid drops
      do_reset();
      vpct = 60; mpct = 50;
      for (int f = 0; f < 2; f++) begin
         for (int p = 0; p < PN; p++) load_frame(p, 3 + int'($urandom_range(7)));
      end
      run_drain("t3_drain", 4000);
      check_eq("t3_nframes", grant_log.size(), 32'd8);
      check_eq("t3_protocol", viol, 32'd0);
      vpct = 100; mpct = 100;

      // Test 4: tag FIFO full stalls arbitration
      do_reset();
      m_axis_flow_tready = 1'b0;
      load_frame(0, 3); load_frame(1, 3); load_frame(2, 3);
      load_frame(3, 3); load_frame(0, 3); load_frame(1, 3);
      repeat (60) tick();
      check_eq("t4_granted", grant_log.size(), 32'd4);
      rdy_seen = 1'b0;
      repeat (10) tick();
      check_eq("t4_stall_rdy", {31'd0, rdy_seen}, 32'd0);
      pop_seen = 1'b0;
      m_axis_flow_tready = 1'b1;
      run_drain("t4_drain", 300);
      check_eq("t4_total", grant_log.size(), 32'd6);
      if (grant_log.size() >= 5) begin
         check_eq("t4_regrant", beat_cyc_log[4] - pop_cyc, 32'd2);
      end
      check_eq("t4_protocol", viol, 32'd0);

      // Test 5: orphan flow ID with empty FIFO
      do_reset();
      orphan_force = 1'b1;
      tick();
      check_eq("t5_sfr", {31'd0, snap_sfr}, 32'd0);
      check_eq("t5_mfv", {31'd0, snap_mfv}, 32'd0);
      check_eq("t5_err_pre", {31'd0, snap_err}, 32'd0);
      orphan_force = 1'b0;
      tick();
      check_eq("t5_err_set", {31'd0, snap_err}, 32'd1);
      repeat (5) tick();
      check_eq("t5_err_sticky", {31'd0, snap_err}, 32'd1);
      check_eq("t5_protocol", viol, 32'd0);
      rstn = 1'b0;
      #1;
      check_eq("t5_err_rst", {31'd0, err_orphan_flow}, 32'd0);

      // Test 6: reset at beat 10 of a port-1 frame
      do_reset();
      load_frame(1, 20);
      n = 0;
      while (p1_beats < 10 && n < 100) begin
         tick();
         n++;
      end
      check_eq("t6_beats", p1_beats, 32'd10);
      check_eq("t6_pre_valid", {31'd0, m_axis_tvalid}, 32'd1);
      rstn = 1'b0;
      #1;
      check_eq("t6_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      check_eq("t6_s_tready", {28'd0, s_axis_tready}, 32'd0);
      check_eq("t6_m_tdata", {24'd0, m_axis_tdata}, 32'd0);
      check_eq("t6_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
      do_reset();
      load_frame(1, 5);
      load_frame(3, 5);
      run_drain("t6_drain", 200);
      check_eq("t6_nframes", grant_log.size(), 32'd2);
      if (grant_log.size() == 2) begin
         check_eq("t6_first_grant", grant_log[0], 32'd1);
         check_eq("t6_second_grant", grant_log[1], 32'd3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
